// File: rtl/alu_pkg.sv
// Shared types for the ALU request sequencer.
// Op encodings and FSM state enum.
package alu_pkg;

   typedef enum logic [2:0] {
      OP_ADD  = 3'b000,
      OP_SUB  = 3'b001,
      OP_AND  = 3'b010,
      OP_ANDN = 3'b011,
      OP_XOR  = 3'b100,
      OP_XNOR = 3'b101,
      OP_SHR  = 3'b110,
      OP_SHL  = 3'b111
   } op_t;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_EXEC  = 2'd1,
      S_DRIVE = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   localparam int DATA_W  = 8;
   localparam int COUNT_W = 16;

   function automatic logic [1:0] op_alu_field(input op_t op);
      return op[2:1];
   endfunction

   function automatic logic op_dir_field(input op_t op);
      return op[0];
   endfunction

endpackage

// File: rtl/alu_sequencer.sv
// Sequences one request at a time through an external ALU:
// latch operands, strobe write, enable bus, return response.
module alu_sequencer
   import alu_pkg::*;
(
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_reqValid,
   output logic               o_reqReady,
   input  logic [2:0]         i_reqOp,
   input  logic [DATA_W-1:0]  i_reqA,
   input  logic [DATA_W-1:0]  i_reqB,
   output logic [DATA_W-1:0]  o_aluA,
   output logic [DATA_W-1:0]  o_aluB,
   output logic [1:0]         o_aluOp,
   output logic               o_subShiftDir,
   output logic               o_aluWr,
   output logic               o_aluNoe,
   input  logic [DATA_W-1:0]  i_aluY,
   input  logic               i_aluNegative,
   input  logic               i_aluNzero,
   output logic               o_rspValid,
   input  logic               i_rspReady,
   output logic [DATA_W-1:0]  o_result,
   output logic               o_negative,
   output logic               o_zero,
   output logic [COUNT_W-1:0] o_opCount
);

   state_t state;
   state_t state_nxt;
   op_t    req_op;
   logic   accept;
   logic   done;

   assign req_op = op_t'(i_reqOp);
   assign accept = (state == S_IDLE) && i_reqValid;
   assign done   = (state == S_RESP) && i_rspReady;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      o_reqReady = 1'b0;
      o_aluWr    = 1'b0;
      o_aluNoe   = 1'b1;
      o_rspValid = 1'b0;
      unique case (state)
         S_IDLE: begin
            o_reqReady = 1'b1;
            if (i_reqValid) state_nxt = S_EXEC;
         end
         S_EXEC: begin
            o_aluWr   = 1'b1;
            state_nxt = S_DRIVE;
         end
         S_DRIVE: begin
            o_aluNoe  = 1'b0;
            state_nxt = S_RESP;
         end
         S_RESP: begin
            o_rspValid = 1'b1;
            if (i_rspReady) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Operand/control registers hold until the next accepted request.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         o_aluA        <= '0;
         o_aluB        <= '0;
         o_aluOp       <= '0;
         o_subShiftDir <= 1'b0;
      end else if (accept) begin
         o_aluA        <= i_reqA;
         o_aluB        <= i_reqB;
         o_aluOp       <= op_alu_field(req_op);
         o_subShiftDir <= op_dir_field(req_op);
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         o_result   <= '0;
         o_negative <= 1'b0;
         o_zero     <= 1'b0;
      end else if (state == S_DRIVE) begin
         o_result   <= i_aluY;
         o_negative <= i_aluNegative;
         o_zero     <= ~i_aluNzero;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         o_opCount <= '0;
      end else if (done) begin
         o_opCount <= o_opCount + 1'b1;
      end
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer with a registered ALU model.
// Directed vectors with hand-computed responses.
module tb_alu_sequencer;

   logic        i_clk = 1'b0;
   logic        i_reset = 1'b1;
   logic        i_reqValid = 1'b0;
   logic        o_reqReady;
   logic [2:0]  i_reqOp = '0;
   logic [7:0]  i_reqA = '0;
   logic [7:0]  i_reqB = '0;
   logic [7:0]  o_aluA, o_aluB;
   logic [1:0]  o_aluOp;
   logic        o_subShiftDir;
   logic        o_aluWr, o_aluNoe;
   logic [7:0]  i_aluY;
   logic        i_aluNegative, i_aluNzero;
   logic        o_rspValid;
   logic        i_rspReady = 1'b1;
   logic [7:0]  o_result;
   logic        o_negative, o_zero;
   logic [15:0] o_opCount;

   int n_pass = 0;
   int n_total = 0;
   logic [9:0] exp_q[$];

   always #5 i_clk = ~i_clk;

   alu_sequencer dut (
      .i_clk(i_clk), .i_reset(i_reset),
      .i_reqValid(i_reqValid), .o_reqReady(o_reqReady),
      .i_reqOp(i_reqOp), .i_reqA(i_reqA), .i_reqB(i_reqB),
      .o_aluA(o_aluA), .o_aluB(o_aluB),
      .o_aluOp(o_aluOp), .o_subShiftDir(o_subShiftDir),
      .o_aluWr(o_aluWr), .o_aluNoe(o_aluNoe),
      .i_aluY(i_aluY), .i_aluNegative(i_aluNegative),
      .i_aluNzero(i_aluNzero),
      .o_rspValid(o_rspValid), .i_rspReady(i_rspReady),
      .o_result(o_result), .o_negative(o_negative),
      .o_zero(o_zero), .o_opCount(o_opCount)
   );

   // ALU model: result register loads on write strobe, bus driven when enabled
   logic [7:0] alu_reg = 8'h00;
   logic [7:0] alu_f;
   always_comb begin
      alu_f = 8'h00;
      case ({o_aluOp, o_subShiftDir})
         3'b000: alu_f = o_aluA + o_aluB;
         3'b001: alu_f = o_aluA - o_aluB;
         3'b010: alu_f = o_aluA & o_aluB;
         3'b011: alu_f = o_aluA & ~o_aluB;
         3'b100: alu_f = o_aluA ^ o_aluB;
         3'b101: alu_f = ~(o_aluA ^ o_aluB);
         3'b110: alu_f = o_aluA >> o_aluB[2:0];
         default: alu_f = o_aluA << o_aluB[2:0];
      endcase
   end
   always @(posedge i_clk) if (o_aluWr) alu_reg <= alu_f;
   assign i_aluY        = o_aluNoe ? 8'hA5 : alu_reg;
   assign i_aluNegative = i_aluY[7];
   assign i_aluNzero    = |i_aluY;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Monitor: pops an expected response on each handshake cycle
   initial begin
      logic [9:0] e;
      forever begin
         @(negedge i_clk);
         #1;
         if (o_rspValid && i_rspReady) begin
            if (exp_q.size() == 0) begin
               chk("sb_unexpected_rsp", {o_result, o_negative, o_zero}, 0);
            end else begin
               e = exp_q.pop_front();
               chk("sb_result", o_result, e[9:2]);
               chk("sb_negative", o_negative, e[1]);
               chk("sb_zero", o_zero, e[0]);
            end
         end
      end
   end

   task automatic issue(input logic [2:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] res,
                        input logic neg, input logic zer);
      int w = 0;
      @(negedge i_clk);
      while (!o_reqReady && w < 50) begin
         @(negedge i_clk);
         w++;
      end
      chk("req_ready_wait", o_reqReady, 1);
      i_reqOp = op; i_reqA = a; i_reqB = b;
      i_reqValid = 1'b1;
      exp_q.push_back({res, neg, zer});
      @(negedge i_clk);
      i_reqValid = 1'b0;
      chk("t1_aluWr", o_aluWr, 1);
      chk("t1_aluNoe", o_aluNoe, 1);
      chk("t1_aluA", o_aluA, a);
      chk("t1_aluB", o_aluB, b);
      chk("t1_ctrl", {o_aluOp, o_subShiftDir}, op);
      @(negedge i_clk);
      chk("t2_aluNoe", o_aluNoe, 0);
      chk("t2_aluWr", o_aluWr, 0);
      @(negedge i_clk);
      chk("t3_rspValid", o_rspValid, 1);
      chk("t3_reqReady", o_reqReady, 0);
   endtask

   initial begin
      logic [15:0] cnt;
      logic [7:0]  held;
      #1;
      chk("rst_aluWr", o_aluWr, 0);
      chk("rst_aluNoe", o_aluNoe, 1);
      chk("rst_rspValid", o_rspValid, 0);
      chk("rst_opCount", o_opCount, 0);
      chk("rst_data", {o_aluA, o_aluB, o_result}, 0);
      chk("rst_ctrl", {o_aluOp, o_subShiftDir, o_negative, o_zero}, 0);
      repeat (2) @(negedge i_clk);
      i_reset = 1'b0;
      #1;
      chk("rst_reqReady", o_reqReady, 1);

      // reset during DRIVE discards the operation
      @(negedge i_clk);
      i_reqOp = 3'b000; i_reqA = 8'h7F; i_reqB = 8'h01;
      i_reqValid = 1'b1;
      @(negedge i_clk);
      i_reqValid = 1'b0;
      @(negedge i_clk);
      chk("pre_rst_noe", o_aluNoe, 0);
      i_reset = 1'b1;
      #1;
      chk("midrst_aluNoe", o_aluNoe, 1);
      chk("midrst_rspValid", o_rspValid, 0);
      chk("midrst_opCount", o_opCount, 0);
      @(negedge i_clk);
      i_reset = 1'b0;

      issue(3'b000, 8'h7F, 8'h01, 8'h80, 1'b1, 1'b0);
      issue(3'b001, 8'h05, 8'h05, 8'h00, 1'b0, 1'b1);
      issue(3'b111, 8'h81, 8'hF9, 8'h02, 1'b0, 1'b0);
      issue(3'b010, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0);
      issue(3'b011, 8'hF0, 8'h3C, 8'hC0, 1'b1, 1'b0);
      issue(3'b100, 8'hAA, 8'h0F, 8'hA5, 1'b1, 1'b0);
      issue(3'b101, 8'hAA, 8'h0F, 8'h5A, 1'b0, 1'b0);
      issue(3'b110, 8'h80, 8'h0B, 8'h10, 1'b0, 1'b0);
      @(negedge i_clk);
      chk("count_after_8", o_opCount, 8);

      // backpressure
      i_rspReady = 1'b0;
      issue(3'b000, 8'h10, 8'h22, 8'h32, 1'b0, 1'b0);
      cnt  = o_opCount;
      held = o_result;
      for (int i = 0; i < 5; i++) begin
         @(negedge i_clk);
         chk("bp_rspValid", o_rspValid, 1);
         chk("bp_result", o_result, held);
         chk("bp_reqReady", o_reqReady, 0);
         chk("bp_opCount", o_opCount, cnt);
      end
      i_rspReady = 1'b1;
      @(negedge i_clk);
      chk("bp_count_inc", o_opCount, cnt + 16'd1);
      chk("bp_reqReady_back", o_reqReady, 1);

      // counter wrap
      force dut.o_opCount = 16'hFFFF;
      #1;
      release dut.o_opCount;
      #1;
      chk("wrap_preload", o_opCount, 16'hFFFF);
      issue(3'b100, 8'h3C, 8'h3C, 8'h00, 1'b0, 1'b1);
      @(negedge i_clk);
      chk("wrap_zero", o_opCount, 16'h0000);

      repeat (4) @(negedge i_clk);
      chk("sb_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset: i_clk and i_reset.
REQ-002 i_clk  in  1  rising-edge clock for all state.
REQ-003 i_reset  in  1  asynchronous, active-high reset.
REQ-004 i_reqValid  in  1  request present; i_reqOp[2:0], i_reqA[7:0], i_reqB[7:0] stable while high.
REQ-005 o_reqReady  out  1  sequencer can accept a request.
REQ-006 i_reqOp  in  3  {aluOp[1:0], subShiftDir}: 000 ADD, 001 SUB, 010 AND, 011 ANDN, 100 XOR, 101 XNOR, 110 SHR, 111 SHL.
REQ-007 i_reqA, i_reqB  in  8 each  operands; B[2:0] is the shift amount for shift ops.
REQ-008 o_aluA, o_aluB  out  8 each  registered operands driven into the ALU.
REQ-009 o_aluOp  out  2; o_subShiftDir  out  1; registered ALU control fields.
REQ-010 o_aluWr  out  1  ALU result-register write strobe.
REQ-011 o_aluNoe  out  1  ALU bus-driver enable, active low.
REQ-012 i_aluY  in  8  ALU bus output; i_aluNegative, i_aluNzero  in  1 each  ALU flags.
REQ-013 o_rspValid  out  1; i_rspReady  in  1  response handshake.
REQ-014 o_result  out  8; o_negative, o_zero  out  1 each  response payload.
REQ-015 o_opCount  out  16  completed-operation counter.

Function
REQ-016 FSM states SHALL be IDLE, EXEC, DRIVE, RESP.
REQ-017 o_reqReady SHALL be 1 only in IDLE.
REQ-018 IDLE: on i_reqValid=1, at that edge latch A, B, op into o_aluA/o_aluB/o_aluOp/o_subShiftDir and go to EXEC.
REQ-019 EXEC (one cycle): o_aluWr=1; next state DRIVE.
REQ-020 DRIVE (one cycle): o_aluNoe=0; at the closing edge capture i_aluY into o_result, i_aluNegative into o_negative, ~i_aluNzero into o_zero; next state RESP.
REQ-021 RESP: o_rspValid=1; payload held stable; on i_rspReady=1 go to IDLE and increment o_opCount.
REQ-022 Latency: the handshake edge at T0 yields o_rspValid=1 in cycle T0+3; minimum issue interval is 4 cycles.
REQ-023 o_aluWr SHALL be 0 and o_aluNoe SHALL be 1 in every state except the one named above.
REQ-024 ALU operand/control registers SHALL hold their values from acceptance until the next acceptance.
REQ-025 i_reqB SHALL be passed unmodified; bits [7:3] are not masked for shift ops.
REQ-026 o_opCount SHALL wrap from 16'hFFFF to 16'h0000.
REQ-027 Requests arriving outside IDLE are not accepted; i_reqValid held high is accepted on the first cycle back in IDLE.
REQ-028 i_rspReady outside RESP SHALL be ignored.

Reset
REQ-029 i_reset SHALL asynchronously force IDLE, at any point including mid-operation; the in-flight operation is discarded and not counted.
REQ-030 Reset values: all data/count outputs 0, o_aluOp=0, o_subShiftDir=0, o_aluWr=0, o_aluNoe=1, o_rspValid=0, o_reqReady=1 once reset deasserts.

Structure
REQ-031 alu_pkg SHALL hold the 3-bit op enum (encodings of REQ-006) and the FSM state enum.
REQ-032 The block SHALL be a single module with no sub-modules.

Verification
REQ-033 ADD A=8'h7F, B=8'h01 -> o_aluOp=00, o_subShiftDir=0, o_aluWr in cycle T0+1, o_aluNoe=0 in T0+2; with the ALU model returning 8'h80 -> o_result=8'h80, o_negative=1, o_zero=0, o_rspValid in T0+3.
REQ-034 SUB A=8'h05, B=8'h05 -> o_aluOp=00, o_subShiftDir=1; ALU returns 8'h00 with i_aluNzero=0 -> o_result=8'h00, o_zero=1, o_negative=0.
REQ-035 SHL A=8'h81, B=8'hF9 -> o_aluB=8'hF9, o_aluOp=11, o_subShiftDir=1; response payload equals the ALU model output.
REQ-036 Backpressure: i_rspReady=0 for 5 cycles -> o_rspValid held, payload stable, o_reqReady=0, o_opCount unchanged; on release, o_opCount +1 and o_reqReady=1 next cycle.
REQ-037 Reset asserted during DRIVE -> o_aluNoe=1, o_rspValid=0 immediately, o_opCount unchanged, next request completes normally.
REQ-038 o_opCount preloaded to 16'hFFFF via 65535 operations (or forced) -> one more completed operation reads 16'h0000.
